// File: rtl/pads_in_cond.sv
// Pad input conditioning: per-channel synchroniser, counter debounce, edge pulses
// and optional sticky edge events / irq (enabled by defining PADS_IN_COND_IRQ_EN).
module pads_in_cond #(
  parameter int              N_CH        = 4,
  parameter int              SYNC_STAGES = 2,
  parameter int              DB_CYCLES   = 16,
  parameter logic [N_CH-1:0] RST_VAL     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pad_in,
  input  logic [N_CH-1:0] db_bypass,
  input  logic [N_CH-1:0] evt_mask,
  input  logic [N_CH-1:0] evt_clr,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] evt_sticky,
  output logic            irq
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] sync_out;
  logic [CW-1:0]   cnt_q  [N_CH];
  logic [CW-1:0]   cnt_d  [N_CH];
  logic [N_CH-1:0] level_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the shift chain a real chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RST_VAL;
    end else begin
      sync_q[0] <= pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    level_d = level;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (db_bypass[i]) begin
        level_d[i] = sync_out[i];
      end else if (sync_out[i] != level[i]) begin
        if (cnt_q[i] == CNT_LAST) level_d[i] = sync_out[i];
        else                      cnt_d[i]   = cnt_q[i] + CW'(1);
      end
    end
  end

  // Edge pulses come from the next-state compare so they line up with level.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= RST_VAL;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      level <= level_d;
      rise  <= level_d & ~level;
      fall  <= ~level_d & level;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef PADS_IN_COND_IRQ_EN
  // A new event wins over a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_sticky <= '0;
      irq        <= 1'b0;
    end else begin
      evt_sticky <= (evt_sticky & ~evt_clr) | ((rise | fall) & evt_mask);
      irq        <= |evt_sticky;
    end
  end
`else
  logic unused_evt;
  assign unused_evt = ^{evt_mask, evt_clr};
  assign evt_sticky = '0;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_pads_in_cond.sv
// Bench for pads_in_cond: directed scenarios plus randomized traffic against a
// run-length reference model (level flips after DB_CYCLES consecutive differing samples).
module tb_pads_in_cond;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int DB = 4;
`ifdef PADS_IN_COND_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] pad_in = '0, db_bypass = '0, evt_mask = '0, evt_clr = '0;
  logic [N-1:0] level, rise, fall, evt_sticky;
  logic         irq;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [N-1:0] m_pipe [S];
  logic [N-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_sticky = '0;
  logic         m_irq = 1'b0;
  int           m_streak [N];

  pads_in_cond #(.N_CH(N), .SYNC_STAGES(S), .DB_CYCLES(DB), .RST_VAL('0)) dut (
    .clk(clk), .rst(rst), .pad_in(pad_in), .db_bypass(db_bypass),
    .evt_mask(evt_mask), .evt_clr(evt_clr), .level(level), .rise(rise),
    .fall(fall), .evt_sticky(evt_sticky), .irq(irq)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, updating the model with the inputs seen at that edge.
  task automatic step();
    logic [N-1:0] s, nl;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < S; k++) m_pipe[k] = '0;
      for (int i = 0; i < N; i++) m_streak[i] = 0;
      m_level = '0; m_rise = '0; m_fall = '0; m_sticky = '0; m_irq = 1'b0;
    end else begin
      s  = m_pipe[S-1];
      nl = m_level;
      for (int i = 0; i < N; i++) begin
        if (db_bypass[i]) begin
          nl[i] = s[i];
          m_streak[i] = 0;
        end else if (s[i] == m_level[i]) begin
          m_streak[i] = 0;
        end else begin
          m_streak[i] = m_streak[i] + 1;
          if (m_streak[i] == DB) begin
            nl[i] = s[i];
            m_streak[i] = 0;
          end
        end
      end
      if (IRQ_EN) begin
        m_irq    = |m_sticky;
        m_sticky = (m_sticky & ~evt_clr) | ((m_rise | m_fall) & evt_mask);
      end
      m_rise  = nl & ~m_level;
      m_fall  = ~nl & m_level;
      m_level = nl;
      for (int k = S - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = pad_in;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pad_in = '0; db_bypass = '0; evt_mask = '0; evt_clr = '0;
    step(); step();
    rst = 1'b0;
    total++;
    if ({level, rise, fall, evt_sticky, irq} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0", {level, rise, fall, evt_sticky, irq});
    end
  endtask

  // Held pad change reaches level exactly S+DB edges later with a one-cycle rise.
  task automatic test_qualify();
    pad_in = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      step();
      total++;
      if (e < 6 && (level !== 4'b0000 || rise !== 4'b0000)) begin
        bad++; $display("FAIL qualify_early edge=%0d level=%b rise=%b want 0000/0000", e, level, rise);
      end else if (e == 6 && (level !== 4'b0001 || rise !== 4'b0001)) begin
        bad++; $display("FAIL qualify_edge6 level=%b rise=%b want 0001/0001", level, rise);
      end else if (e == 7 && (level !== 4'b0001 || rise !== 4'b0000)) begin
        bad++; $display("FAIL qualify_after level=%b rise=%b want 0001/0000", level, rise);
      end
    end
  endtask

  // A 3-cycle pulse is shorter than the qualification window and is rejected.
  task automatic test_glitch();
    pad_in[1] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      if (e == 3) pad_in[1] = 1'b0;
      step();
      total++;
      if (level !== 4'b0001 || rise !== 4'b0000 || fall !== 4'b0000) begin
        bad++; $display("FAIL glitch edge=%0d level=%b rise=%b fall=%b want 0001/0000/0000", e, level, rise, fall);
      end
    end
  endtask

  // Bypassed channel follows its pad after S+1 edges, in both directions.
  task automatic test_bypass();
    db_bypass = 4'b0100;
    for (int d = 0; d < 2; d++) begin
      pad_in[2] = (d == 0);
      for (int e = 1; e <= 4; e++) begin
        step();
        total++;
        if (level[2] !== (e >= 3 ? pad_in[2] : ~pad_in[2])) begin
          bad++; $display("FAIL bypass dir=%0d edge=%0d level2=%b want=%b", d, e, level[2], (e >= 3 ? pad_in[2] : ~pad_in[2]));
        end
      end
    end
    db_bypass = '0;
  endtask

  task automatic test_irq();
    evt_mask = 4'hF;
    pad_in[0] = 1'b0;
    for (int e = 0; e < 6; e++) step();
    total++;
    if (fall !== 4'b0001) begin bad++; $display("FAIL irq_fall got=%b want=0001", fall); end
    step();
    total++;
    if (evt_sticky !== (IRQ_EN ? 4'b0001 : 4'b0000) || irq !== 1'b0) begin
      bad++; $display("FAIL irq_sticky sticky=%b irq=%b want=%b/0", evt_sticky, irq, (IRQ_EN ? 4'b0001 : 4'b0000));
    end
    step();
    total++;
    if (irq !== IRQ_EN) begin bad++; $display("FAIL irq_delay irq=%b want=%b", irq, IRQ_EN); end
    // New edge coinciding with a clear: set wins.
    db_bypass[0] = 1'b1; pad_in[0] = 1'b1;
    step(); step(); step();
    total++;
    if (rise !== 4'b0001) begin bad++; $display("FAIL irq_rise got=%b want=0001", rise); end
    evt_clr = 4'b0001;
    step();
    total++;
    if (evt_sticky !== (IRQ_EN ? 4'b0001 : 4'b0000)) begin
      bad++; $display("FAIL irq_set_wins sticky=%b want=%b", evt_sticky, (IRQ_EN ? 4'b0001 : 4'b0000));
    end
    step();
    evt_clr = '0;
    total++;
    if (evt_sticky !== 4'b0000) begin bad++; $display("FAIL irq_clear sticky=%b want=0000", evt_sticky); end
    step(); step();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_drop irq=%b want=0", irq); end
    db_bypass = '0; evt_mask = '0;
  endtask

  // Reset mid-count discards progress; level needs a full requalification.
  task automatic test_reset_mid();
    pad_in = 4'hF;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({level, rise, fall, evt_sticky, irq} !== '0) begin
      bad++; $display("FAIL reset_mid got=%h want=0", {level, rise, fall, evt_sticky, irq});
    end
    for (int e = 1; e <= 6; e++) begin
      step();
      total++;
      if (e < 6 && (level !== 4'h0 || rise !== 4'h0 || fall !== 4'h0)) begin
        bad++; $display("FAIL requal_early edge=%0d level=%h rise=%h fall=%h want 0/0/0", e, level, rise, fall);
      end else if (e == 6 && (level !== 4'hF || rise !== 4'hF)) begin
        bad++; $display("FAIL requal_edge6 level=%h rise=%h want F/F", level, rise);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) pad_in[i] = ~pad_in[i];
      if ($urandom_range(0, 19) == 0) db_bypass = 4'($urandom);
      evt_mask = 4'($urandom);
      evt_clr  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      rst      = ($urandom_range(0, 99) == 0);
      step();
      total++;
      if ({level, rise, fall, evt_sticky, irq} !== {m_level, m_rise, m_fall, m_sticky, m_irq}) begin
        bad++;
        $display("FAIL random cyc=%0d got l=%b r=%b f=%b s=%b i=%b want l=%b r=%b f=%b s=%b i=%b",
                 c, level, rise, fall, evt_sticky, irq, m_level, m_rise, m_fall, m_sticky, m_irq);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_glitch();
    test_bypass();
    test_irq();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
